// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side handshake for the hazard scoreboard: D/E/M/W register fields in,
// stall/flush/forward controls out.
interface hazard_if #(
    parameter int REG_AW = 5
);
    logic              ValidD, RegWriteD, LongOpD;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic              ResultSrcE_zero, PCSrcE;
    logic              RegWriteM, RegWriteW;
    logic [REG_AW-1:0] RdM, RdW;
    logic              LongDoneW;
    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;

    modport master (
        output ValidD, RegWriteD, LongOpD, Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE,
               ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW, RdM, RdW, LongDoneW,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
    );

    modport slave (
        input  ValidD, RegWriteD, LongOpD, Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE,
               ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW, RdM, RdW, LongDoneW,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding, load-use/branch hazard control and a register scoreboard that lets
// variable-latency long ops complete out of order through W.
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int BYPASS_DONE  = 1,
    parameter int PERF_W       = 32,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_if.slave             hz,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [CNT_W-1:0]    inflight_o,
    output logic [PERF_W-1:0]   stall_cycles_o
);
    logic [NUM_REGS-1:0] pending, pendingNxt, doneClr, pendEff;
    logic [CNT_W-1:0]    inflight;
    logic [PERF_W-1:0]   stallCycles;
    logic                lwStall, rawStall, wawStall, fullStall, stallD;
    logic                issue, doneValid;

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.RdM != '0 && hz.RdM == hz.Rs1E)      hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != '0 && hz.RdW == hz.Rs1E) hz.ForwardAE = 2'b01;
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.RdM != '0 && hz.RdM == hz.Rs2E)      hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != '0 && hz.RdW == hz.Rs2E) hz.ForwardBE = 2'b01;
    end

    // With bypass, a completion in W already satisfies a waiting reader this cycle.
    always_comb begin
        doneClr = '0;
        if (BYPASS_DONE != 0 && hz.LongDoneW) doneClr[hz.RdW] = 1'b1;
        pendEff    = pending & ~doneClr;
        pendEff[0] = 1'b0;
    end

    assign lwStall   = hz.ResultSrcE_zero && hz.RdE != '0 &&
                       (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    assign rawStall  = pendEff[hz.Rs1D] || pendEff[hz.Rs2D];
    assign wawStall  = hz.RegWriteD && pendEff[hz.RdD];
    assign fullStall = hz.LongOpD && inflight == CNT_W'(MAX_INFLIGHT) && !hz.LongDoneW;
    assign stallD    = hz.ValidD && (lwStall || rawStall || wawStall || fullStall);

    assign hz.StallF = stallD;
    assign hz.StallD = stallD;
    assign hz.FlushD = hz.PCSrcE;
    assign hz.FlushE = hz.PCSrcE || stallD;

    assign issue     = hz.ValidD && hz.LongOpD && hz.RegWriteD && hz.RdD != '0 &&
                       !stallD && !hz.PCSrcE;
    // Completions for registers not pending (e.g. ops lost across reset) are ignored.
    assign doneValid = hz.LongDoneW && pending[hz.RdW];

    // Clear before set: a same-cycle issue to the completing register keeps it pending.
    always_comb begin
        pendingNxt = pending;
        if (hz.LongDoneW) pendingNxt[hz.RdW] = 1'b0;
        if (issue)        pendingNxt[hz.RdD] = 1'b1;
        pendingNxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            inflight    <= '0;
            stallCycles <= '0;
        end else begin
            pending <= pendingNxt;
            if (issue && !doneValid)
                inflight <= inflight + CNT_W'(1);
            else if (doneValid && !issue && inflight != '0)
                inflight <= inflight - CNT_W'(1);
            if (stallD && stallCycles != '1)
                stallCycles <= stallCycles + PERF_W'(1);
        end
    end

    assign pending_o      = pending;
    assign inflight_o     = inflight;
    assign stall_cycles_o = stallCycles;
endmodule
